simon_seq_ctrl: RTL and testbench
=================================

Name: simon_seq_ctrl

Overview:
- Parametrised game-sequence controller for the memory game: grows a random color sequence and replays it on the color output.
- Checks the player's repeat of the sequence and tracks score and high score.
- Successor to the fixed 4-color, 32-deep controller. Adds configurable color width and depth, a blanking gap between displayed colors, an input-idle timeout, tempo speed-up, and held end-of-game flags.
- Sits between the input sync/encoder, the LFSR (RAND), the shared tick timer and the LED/sound drivers.

Parameters:
- COLOR_W, 2, bits per color (2**COLOR_W colors).
- DEPTH, 32, maximum sequence length; power of two, >=2.
- TIMEOUT_TICKS, 8, consecutive TIMER_PULSEs without input in INPUT before loss; >=1.
- SPEEDUP_LOG2, 2, SPEED increments every 2**SPEEDUP_LOG2 rounds.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous, active-low reset.
- IN  in  COLOR_W  player color, already synced and encoded.
- IN_VALID  in  1  one-cycle strobe, IN is valid.
- RAND  in  COLOR_W  random color, sampled in ADD.
- START_GAME  in  1  start request; ignored outside IDLE/END.
- FAST_MODE  in  1  enables tempo speed-up; sampled at game start.
- TIMER_PULSE  in  1  one-cycle strobe, one timer period elapsed since the last TIMER_GO.
- TIMER_GO  out  1  one-cycle (re)start strobe to the timer.
- SPEED  out  2  tempo select to the timer; 0 is slowest.
- OUT  out  COLOR_W  displayed color.
- OUT_ENA  out  1  display enable.
- SCORE  out  $clog2(DEPTH)+1  completed rounds in the current/last game.
- HIGH_SCORE  out  $clog2(DEPTH)+1  best score since reset.
- WIN  out  1  level; set in END after a full-DEPTH game.
- LOSE  out  1  level; set in END after a mistake or timeout.
- HS  out  1  one-cycle pulse when a new high score is recorded.

Behaviour:
- Reset: all outputs 0 except OUT = all-ones. State IDLE, L = 0, i = 0, idle counter 0. Sequence RAM is not reset. Reset mid-game aborts immediately, with no HS pulse.
- Registers:
  - L: sequence length, 0..DEPTH, $clog2(DEPTH)+1 bits.
  - i: position index.
  - idle: timeout counter, saturating.
  - fast: FAST_MODE latched at game start.
- IDLE/END + START_GAME: clear WIN, LOSE, L, SCORE and i; latch fast; go to ADD.
- ADD:
  - If L == DEPTH, go to WIN.
  - Otherwise seq[L] <= RAND; L <= L+1; i <= 0; go to SHOW. Takes one cycle.
- SHOW (one cycle): OUT <= seq[i]; OUT_ENA <= 1; TIMER_GO pulse; go to SHOW_WAIT.
- SHOW_WAIT: on TIMER_PULSE, OUT_ENA <= 0 and TIMER_GO pulse, then go to GAP.
- GAP: on TIMER_PULSE:
  - If i == L-1, set i <= 0, idle <= 0, pulse TIMER_GO and go to INPUT.
  - Otherwise i <= i+1 and go to SHOW.
- INPUT:
  - IN_VALID with IN == seq[i]: echo OUT <= IN for display; idle <= 0; TIMER_GO pulse.
    - If i == L-1: SCORE <= L; go to ADD.
    - Otherwise i <= i+1.
  - IN_VALID with a mismatch: go to LOSE.
  - TIMER_PULSE without IN_VALID: idle <= idle+1 and TIMER_GO pulse. If idle+1 == TIMEOUT_TICKS, go to LOSE.
  - IN_VALID and TIMER_PULSE in the same cycle: the input takes priority and the pulse is discarded.
- WIN (one cycle): set WIN; go to FINISH.
- LOSE (one cycle): set LOSE, OUT_ENA <= 0; go to FINISH.
- FINISH (one cycle):
  - If SCORE > HIGH_SCORE, HIGH_SCORE <= SCORE and pulse HS.
  - Go to END. WIN/LOSE hold until the next START_GAME.
- SPEED: fast ? min(L >> SPEEDUP_LOG2, 3) : 0, registered.
- Ignored inputs:
  - IN_VALID outside INPUT.
  - TIMER_PULSE outside the wait states and INPUT.
  - START_GAME outside IDLE/END.
- Full-depth win: SCORE == DEPTH and HIGH_SCORE saturates at DEPTH. No counter wraps.

Decomposition:
- Shared package (constants.vh style) holds:
  - the state encodings IDLE, ADD, SHOW, SHOW_WAIT, GAP, INPUT, WIN, LOSE, FINISH, END (4-bit);
  - the SPEED encoding.
- One sub-module, simon_seq_ram: DEPTH x COLOR_W, one synchronous write port, one combinational read port, no reset.

Test Plan:
1. Reset, START_GAME, RAND = 2, then one pulse per timer wait → OUT = 2 with OUT_ENA = 1 for one period, then a gap, then INPUT. IN = 2 → SCORE = 1, a new round starts, seq[1] = RAND.
2. Round 3 with seq = {1,3,0}, player enters 1,3,2 → LOSE = 1, WIN = 0. FINISH sets HIGH_SCORE = 2 with a one-cycle HS pulse. Flags hold until START_GAME.
3. INPUT with no IN_VALID and 8 TIMER_PULSEs → LOSE asserted after the 8th. Seven pulses then a valid input → no loss, idle counter cleared.
4. DEPTH = 4, all rounds correct → WIN = 1, SCORE = 4, HIGH_SCORE = 4, HS pulse. A second identical game → no HS pulse.
5. FAST_MODE = 1, SPEEDUP_LOG2 = 2 → SPEED is 0 for L = 1..3, 1 for L = 4..7, and saturates at 3. FAST_MODE = 0 → SPEED stays 0.
6. Edge cases:
   - IN_VALID (correct) and TIMER_PULSE in the same cycle → input accepted, idle = 0.
   - RST_N low mid-SHOW → all outputs at reset values, IDLE, no HS pulse.

Source files
------------

// File: rtl/simon_seq_ctrl_pkg.sv
// Shared encodings for the memory-game sequence controller: FSM states and
// the tempo select driven to the tick timer.
package simon_seq_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_ADD       = 4'd1,
      S_SHOW      = 4'd2,
      S_SHOW_WAIT = 4'd3,
      S_GAP       = 4'd4,
      S_INPUT     = 4'd5,
      S_WIN       = 4'd6,
      S_LOSE      = 4'd7,
      S_FINISH    = 4'd8,
      S_END       = 4'd9
   } state_e;

   localparam logic [1:0] SPEED_SLOW = 2'd0;
   localparam logic [1:0] SPEED_MAX  = 2'd3;

   // Tempo tier is the sequence length already divided down; clamp to the
   // fastest setting the timer supports.
   function automatic logic [1:0] speed_sel(input logic fast, input logic [31:0] tier);
      logic [1:0] sel;
      sel = SPEED_SLOW;
      if (fast) begin
         sel = (tier > 32'd3) ? SPEED_MAX : tier[1:0];
      end
      return sel;
   endfunction

endpackage

// File: rtl/simon_seq_ctrl_ram.sv
// Sequence storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; a new game overwrites from index 0.
module simon_seq_ram
   import simon_seq_ctrl_pkg::*;
#(
   parameter int COLOR_W = 2,
   parameter int DEPTH   = 32
) (
   input  logic                     CLK,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [COLOR_W-1:0]       wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [COLOR_W-1:0]       rdata
);

   logic [COLOR_W-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/simon_seq_ctrl.sv
// Memory-game sequence controller: grows a random color sequence, replays it
// with blanking gaps, checks the player's repeat and keeps score/high score.
module simon_seq_ctrl
   import simon_seq_ctrl_pkg::*;
#(
   parameter int COLOR_W       = 2,
   parameter int DEPTH         = 32,
   parameter int TIMEOUT_TICKS = 8,
   parameter int SPEEDUP_LOG2  = 2
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic [COLOR_W-1:0]     IN,
   input  logic                   IN_VALID,
   input  logic [COLOR_W-1:0]     RAND,
   input  logic                   START_GAME,
   input  logic                   FAST_MODE,
   input  logic                   TIMER_PULSE,
   output logic                   TIMER_GO,
   output logic [1:0]             SPEED,
   output logic [COLOR_W-1:0]     OUT,
   output logic                   OUT_ENA,
   output logic [$clog2(DEPTH):0] SCORE,
   output logic [$clog2(DEPTH):0] HIGH_SCORE,
   output logic                   WIN,
   output logic                   LOSE,
   output logic                   HS
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LW    = AW + 1;
   localparam int IDW   = $clog2(TIMEOUT_TICKS + 1);
   localparam int IDX_W = IDW + 1;

   localparam logic [LW-1:0]    DEPTH_L   = LW'(DEPTH);
   localparam logic [LW-1:0]    ONE_L     = LW'(1);
   localparam logic [AW-1:0]    ONE_A     = AW'(1);
   localparam logic [IDW-1:0]   IDLE_SAT  = IDW'(TIMEOUT_TICKS);
   localparam logic [IDX_W-1:0] TIMEOUT_X = IDX_W'(TIMEOUT_TICKS);

   state_e              state_q, state_d;
   logic [LW-1:0]       len_q, len_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic [IDW-1:0]      idle_q, idle_d;
   logic                fast_q, fast_d;
   logic [COLOR_W-1:0]  out_q, out_d;
   logic                ena_q, ena_d;
   logic [LW-1:0]       score_q, score_d;
   logic [LW-1:0]       high_q, high_d;
   logic                win_q, win_d;
   logic                lose_q, lose_d;
   logic                hs_q, hs_d;
   logic                go_q, go_d;
   logic [1:0]          speed_q, speed_d;

   logic                ram_we;
   logic [COLOR_W-1:0]  ram_rdata;
   logic                idx_last;
   logic [IDX_W-1:0]    idle_inc;

   simon_seq_ram #(
      .COLOR_W (COLOR_W),
      .DEPTH   (DEPTH)
   ) u_ram (
      .CLK   (CLK),
      .we    (ram_we),
      .waddr (len_q[AW-1:0]),
      .wdata (RAND),
      .raddr (idx_q),
      .rdata (ram_rdata)
   );

   assign idx_last = ({1'b0, idx_q} == (len_q - ONE_L));
   assign idle_inc = {1'b0, idle_q} + IDX_W'(1);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      idle_d  = idle_q;
      fast_d  = fast_q;
      out_d   = out_q;
      ena_d   = ena_q;
      score_d = score_q;
      high_d  = high_q;
      win_d   = win_q;
      lose_d  = lose_q;
      hs_d    = 1'b0;
      go_d    = 1'b0;
      ram_we  = 1'b0;
      speed_d = speed_sel(fast_q, 32'(len_q >> SPEEDUP_LOG2));

      case (state_q)
         S_IDLE, S_END: begin
            if (START_GAME) begin
               win_d   = 1'b0;
               lose_d  = 1'b0;
               len_d   = '0;
               score_d = '0;
               idx_d   = '0;
               fast_d  = FAST_MODE;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            if (len_q == DEPTH_L) begin
               state_d = S_WIN;
            end else begin
               ram_we  = 1'b1;
               len_d   = len_q + ONE_L;
               idx_d   = '0;
               state_d = S_SHOW;
            end
         end
         S_SHOW: begin
            out_d   = ram_rdata;
            ena_d   = 1'b1;
            go_d    = 1'b1;
            state_d = S_SHOW_WAIT;
         end
         S_SHOW_WAIT: begin
            if (TIMER_PULSE) begin
               ena_d   = 1'b0;
               go_d    = 1'b1;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (TIMER_PULSE) begin
               if (idx_last) begin
                  idx_d   = '0;
                  idle_d  = '0;
                  go_d    = 1'b1;
                  state_d = S_INPUT;
               end else begin
                  idx_d   = idx_q + ONE_A;
                  state_d = S_SHOW;
               end
            end
         end
         S_INPUT: begin
            // A player entry wins over a coincident timer pulse.
            if (IN_VALID) begin
               if (IN == ram_rdata) begin
                  out_d  = IN;
                  idle_d = '0;
                  go_d   = 1'b1;
                  if (idx_last) begin
                     score_d = len_q;
                     state_d = S_ADD;
                  end else begin
                     idx_d = idx_q + ONE_A;
                  end
               end else begin
                  state_d = S_LOSE;
               end
            end else if (TIMER_PULSE) begin
               idle_d = (idle_q == IDLE_SAT) ? idle_q : idle_inc[IDW-1:0];
               go_d   = 1'b1;
               if (idle_inc == TIMEOUT_X) begin
                  state_d = S_LOSE;
               end
            end
         end
         S_WIN: begin
            win_d   = 1'b1;
            state_d = S_FINISH;
         end
         S_LOSE: begin
            lose_d  = 1'b1;
            ena_d   = 1'b0;
            state_d = S_FINISH;
         end
         S_FINISH: begin
            if (score_q > high_q) begin
               high_d = score_q;
               hs_d   = 1'b1;
            end
            state_d = S_END;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         idle_q  <= '0;
         fast_q  <= 1'b0;
         out_q   <= '1;
         ena_q   <= 1'b0;
         score_q <= '0;
         high_q  <= '0;
         win_q   <= 1'b0;
         lose_q  <= 1'b0;
         hs_q    <= 1'b0;
         go_q    <= 1'b0;
         speed_q <= SPEED_SLOW;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         idle_q  <= idle_d;
         fast_q  <= fast_d;
         out_q   <= out_d;
         ena_q   <= ena_d;
         score_q <= score_d;
         high_q  <= high_d;
         win_q   <= win_d;
         lose_q  <= lose_d;
         hs_q    <= hs_d;
         go_q    <= go_d;
         speed_q <= speed_d;
      end
   end

   assign TIMER_GO   = go_q;
   assign SPEED      = speed_q;
   assign OUT        = out_q;
   assign OUT_ENA    = ena_q;
   assign SCORE      = score_q;
   assign HIGH_SCORE = high_q;
   assign WIN        = win_q;
   assign LOSE       = lose_q;
   assign HS         = hs_q;

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Bench for simon_seq_ctrl: acts as player and tick timer, keeps its own copy
// of the color sequence and scores, and plays a table of games plus corner cases.
module tb_simon_seq_ctrl;

   localparam int CW    = 2;
   localparam int DEPTH = 16;
   localparam int TMO   = 8;
   localparam int SUL   = 2;
   localparam int SW    = $clog2(DEPTH) + 1;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic [CW-1:0] IN = '0;
   logic          IN_VALID = 1'b0;
   logic [CW-1:0] RAND = '0;
   logic          START_GAME = 1'b0;
   logic          FAST_MODE = 1'b0;
   logic          TIMER_PULSE = 1'b0;
   logic          TIMER_GO;
   logic [1:0]    SPEED;
   logic [CW-1:0] OUT;
   logic          OUT_ENA;
   logic [SW-1:0] SCORE;
   logic [SW-1:0] HIGH_SCORE;
   logic          WIN;
   logic          LOSE;
   logic          HS;

   simon_seq_ctrl #(
      .COLOR_W       (CW),
      .DEPTH         (DEPTH),
      .TIMEOUT_TICKS (TMO),
      .SPEEDUP_LOG2  (SUL)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .IN          (IN),
      .IN_VALID    (IN_VALID),
      .RAND        (RAND),
      .START_GAME  (START_GAME),
      .FAST_MODE   (FAST_MODE),
      .TIMER_PULSE (TIMER_PULSE),
      .TIMER_GO    (TIMER_GO),
      .SPEED       (SPEED),
      .OUT         (OUT),
      .OUT_ENA     (OUT_ENA),
      .SCORE       (SCORE),
      .HIGH_SCORE  (HIGH_SCORE),
      .WIN         (WIN),
      .LOSE        (LOSE),
      .HS          (HS)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit fast;
      int fail_round;   // 0: play every round and win
      int fail_kind;    // 0: wrong color, 1: idle timeout
      int exp_score;
      bit exp_win;
      bit exp_hs;
      int exp_high;
   } game_t;

   game_t         games[6];
   int            n_checks = 0;
   int            n_fail = 0;
   logic [CW-1:0] seq[$];
   logic [CW-1:0] rand_cur;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic wait_go(input string what);
      for (int k = 0; k < 40 && !TIMER_GO; k++) @(negedge CLK);
      check(what, int'(TIMER_GO), 1);
   endtask

   task automatic pulse();
      TIMER_PULSE = 1'b1;
      @(negedge CLK);
      TIMER_PULSE = 1'b0;
   endtask

   // Random dead time before the timer fires, with stray inputs the
   // controller must ignore while it is displaying.
   task automatic idle_delay();
      int n;
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
         IN_VALID   = 1'($urandom_range(0, 1));
         IN         = CW'($urandom);
         START_GAME = 1'($urandom_range(0, 1));
         @(negedge CLK);
      end
      IN_VALID   = 1'b0;
      START_GAME = 1'b0;
   endtask

   task automatic enter(input logic [CW-1:0] c, input bit with_pulse);
      IN          = c;
      IN_VALID    = 1'b1;
      TIMER_PULSE = with_pulse;
      @(negedge CLK);
      IN_VALID    = 1'b0;
      TIMER_PULSE = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, " OUT"}, int'(OUT), (1 << CW) - 1);
      check({tag, " OUT_ENA"}, int'(OUT_ENA), 0);
      check({tag, " TIMER_GO"}, int'(TIMER_GO), 0);
      check({tag, " SPEED"}, int'(SPEED), 0);
      check({tag, " SCORE"}, int'(SCORE), 0);
      check({tag, " HIGH_SCORE"}, int'(HIGH_SCORE), 0);
      check({tag, " WIN"}, int'(WIN), 0);
      check({tag, " LOSE"}, int'(LOSE), 0);
      check({tag, " HS"}, int'(HS), 0);
   endtask

   task automatic start_game(input bit fast, input int first);
      rand_cur   = (first < 0) ? CW'($urandom) : CW'(first);
      RAND       = rand_cur;
      FAST_MODE  = fast;
      START_GAME = 1'b1;
      tick();
      START_GAME = 1'b0;
      FAST_MODE  = ~fast;
      seq.delete();
      check("start WIN clear", int'(WIN), 0);
      check("start LOSE clear", int'(LOSE), 0);
      check("start SCORE clear", int'(SCORE), 0);
   endtask

   task automatic show_round(input int len);
      for (int j = 0; j < len; j++) begin
         wait_go("show go");
         check("show color", int'(OUT), int'(seq[j]));
         check("show ena", int'(OUT_ENA), 1);
         idle_delay();
         pulse();
         wait_go("blank go");
         check("blank ena", int'(OUT_ENA), 0);
         idle_delay();
         pulse();
      end
      wait_go("input go");
   endtask

   task automatic next_rand();
      rand_cur = CW'($urandom);
      RAND     = rand_cur;
   endtask

   task automatic finish_check(input int exp_win, input int exp_lose, input int exp_hs,
                               input int exp_score, input int exp_high);
      for (int k = 0; k < 20 && !(WIN || LOSE); k++) tick();
      check("end WIN", int'(WIN), exp_win);
      check("end LOSE", int'(LOSE), exp_lose);
      check("end OUT_ENA", int'(OUT_ENA), 0);
      tick();
      check("HS pulse", int'(HS), exp_hs);
      check("HIGH_SCORE", int'(HIGH_SCORE), exp_high);
      check("final SCORE", int'(SCORE), exp_score);
      tick();
      check("HS one cycle", int'(HS), 0);
      for (int k = 0; k < 3; k++) begin
         TIMER_PULSE = 1'($urandom_range(0, 1));
         IN_VALID    = 1'($urandom_range(0, 1));
         tick();
      end
      TIMER_PULSE = 1'b0;
      IN_VALID    = 1'b0;
      check("WIN held", int'(WIN), exp_win);
      check("LOSE held", int'(LOSE), exp_lose);
      check("HS quiet in END", int'(HS), 0);
   endtask

   task automatic play_game(input game_t g);
      bit            done;
      int            p;
      int            tier;
      logic [CW-1:0] w;
      done = 1'b0;
      start_game(g.fast, -1);
      for (int r = 1; r <= DEPTH && !done; r++) begin
         seq.push_back(rand_cur);
         show_round(r);
         tier = r / (2 ** SUL);
         if (tier > 3) tier = 3;
         check("SPEED", int'(SPEED), g.fast ? tier : 0);
         if (r == g.fail_round) begin
            done = 1'b1;
            if (g.fail_kind == 0) begin
               p = $urandom_range(0, r - 1);
               for (int j = 0; j < p; j++) enter(seq[j], 1'b0);
               w = seq[p] + 1'b1;
               enter(w, 1'b0);
            end else begin
               for (int k = 0; k < TMO - 1; k++) pulse();
               check("no early timeout", int'(LOSE), 0);
               pulse();
            end
         end else begin
            for (int j = 0; j < r; j++) begin
               if (j == r - 1) next_rand();
               enter(seq[j], 1'b0);
               check("echo OUT", int'(OUT), int'(seq[j]));
               check("accept go", int'(TIMER_GO), 1);
            end
            check("round SCORE", int'(SCORE), r);
            tick();
         end
      end
      finish_check(int'(g.exp_win), int'(!g.exp_win), int'(g.exp_hs), g.exp_score, g.exp_high);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      games[0] = '{fast: 1'b0, fail_round: 3, fail_kind: 0, exp_score: 2,     exp_win: 1'b0, exp_hs: 1'b1, exp_high: 2};
      games[1] = '{fast: 1'b1, fail_round: 6, fail_kind: 1, exp_score: 5,     exp_win: 1'b0, exp_hs: 1'b1, exp_high: 5};
      games[2] = '{fast: 1'b0, fail_round: 2, fail_kind: 0, exp_score: 1,     exp_win: 1'b0, exp_hs: 1'b0, exp_high: 5};
      games[3] = '{fast: 1'b1, fail_round: 0, fail_kind: 0, exp_score: DEPTH, exp_win: 1'b1, exp_hs: 1'b1, exp_high: DEPTH};
      games[4] = '{fast: 1'b0, fail_round: 0, fail_kind: 0, exp_score: DEPTH, exp_win: 1'b1, exp_hs: 1'b0, exp_high: DEPTH};
      games[5] = '{fast: 1'b1, fail_round: 1, fail_kind: 1, exp_score: 0,     exp_win: 1'b0, exp_hs: 1'b0, exp_high: DEPTH};

      repeat (3) tick();
      check_reset("reset");
      RST_N = 1'b1;
      tick();
      check_reset("idle");

      for (int gi = 0; gi < 6; gi++) play_game(games[gi]);

      // Idle counter: cleared by a correct entry, coincident pulse discarded.
      start_game(1'b0, 2);
      seq.push_back(rand_cur);
      show_round(1);
      for (int k = 0; k < TMO - 1; k++) pulse();
      check("7 idle ticks no loss", int'(LOSE), 0);
      rand_cur = 1;
      RAND     = rand_cur;
      enter(2, 1'b0);
      check("first round SCORE", int'(SCORE), 1);
      tick();
      seq.push_back(rand_cur);
      show_round(2);
      for (int k = 0; k < TMO - 1; k++) pulse();
      enter(seq[0], 1'b1);
      check("simultaneous echo", int'(OUT), int'(seq[0]));
      check("simultaneous go", int'(TIMER_GO), 1);
      for (int k = 0; k < TMO - 1; k++) pulse();
      check("pulse discarded, idle cleared", int'(LOSE), 0);
      next_rand();
      enter(seq[1], 1'b0);
      check("second round SCORE", int'(SCORE), 2);
      tick();
      seq.push_back(rand_cur);
      show_round(3);
      for (int k = 0; k < TMO; k++) pulse();
      finish_check(0, 1, 0, 2, DEPTH);

      // Reset while a color is on display.
      start_game(1'b1, -1);
      wait_go("pre-reset show go");
      check("pre-reset ena", int'(OUT_ENA), 1);
      RST_N = 1'b0;
      #1;
      check_reset("async reset");
      tick();
      check("HS during reset", int'(HS), 0);
      tick();
      RST_N = 1'b1;
      tick();
      check_reset("after reset");
      pulse();
      check("pulse ignored in IDLE", int'(TIMER_GO), 0);
      start_game(1'b0, -1);
      seq.push_back(rand_cur);
      show_round(1);
      enter(seq[0] + 1'b1, 1'b0);
      finish_check(0, 1, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
